m32_8: RTL and testbench
========================

M32_8 -- requirements
Module: m32_8

Interface
REQ-001 Parameter IDLE_BYTE, default 8'hBC, is the byte driven on data_32_8 when no valid data is being sent.
REQ-002 clk_4f  input  1  single clock at byte rate; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_input  input  32  word to serialize; byte [31:24] is sent first.
REQ-005 valid_input  input  1  data_input is valid this cycle.
REQ-006 ready_32_8  output  1  block can accept a word this cycle.
REQ-007 data_32_8  output  8  serialized byte, registered.
REQ-008 valid_32_8  output  1  data_32_8 carries word data, registered.
REQ-009 sincout  output  1  registered; high on the cycle data_32_8 carries byte 0 ([31:24]) of a valid word.

Function
REQ-010 A word SHALL be accepted on a rising edge where valid_input=1 and ready_32_8=1; with ready_32_8=0, data_input is ignored and not stored.
REQ-011 Storage SHALL be a 2-entry word FIFO (count 0..2) feeding a serializer with byte index 0..3.
REQ-012 ready_32_8 SHALL equal (count<2), combinational from count only, with no same-cycle dependence on pop.
REQ-013 Serializer states SHALL be IDLE (no word loaded) and SEND (word loaded; index selects byte).
REQ-014 IDLE -> SEND SHALL occur on the cycle the FIFO is non-empty: pop the head word, drive byte 0 on the next edge.
REQ-015 In SEND, index SHALL advance 0->1->2->3 one step per cycle; bytes SHALL be [31:24], [23:16], [15:8], [7:0].
REQ-016 On index 3 with FIFO non-empty, the next word SHALL be popped and its byte 0 SHALL follow with no bubble; with FIFO empty, the state SHALL return to IDLE.
REQ-017 Latency SHALL be exactly 2 cycles: with the block idle, a word accepted at edge N appears on the FIFO at N, is popped at N+1, and byte 0 is output at N+2.
REQ-018 In IDLE, data_32_8 SHALL be IDLE_BYTE, valid_32_8=0 and sincout=0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve word order. Push at count=2 is impossible because ready_32_8=0.
REQ-020 Sustained valid_input=1 SHALL yield back-to-back words at 1 word per 4 cycles. ready_32_8 SHALL deassert only while 2 words are queued.
REQ-021 valid_32_8 SHALL be 1 for all 4 bytes of every word, and sincout SHALL pulse once per word.
REQ-022 No word SHALL be dropped, duplicated or reordered. Byte order SHALL be the exact inverse of the 8-to-32 packer, so m32_8 followed by m8_32 is lossless.

Reset
REQ-023 While reset=1 at a rising edge: count=0, state=IDLE, index=0, data_32_8=IDLE_BYTE, valid_32_8=0, sincout=0.
REQ-024 ready_32_8 SHALL be 0 while reset=1 and 1 from the first edge after reset deasserts.
REQ-025 Reset asserted mid-word SHALL discard the partial word and all queued words. Output SHALL be IDLE_BYTE on the next edge.
REQ-026 FIFO data storage need not be reset; only control state and outputs SHALL be reset.

Structure
REQ-027 IDLE_BYTE (8'hBC, K28.5 comma), byte-index width (2) and FIFO depth (2) SHALL live in the shared PHY constants include, also used by m8_32.
REQ-028 The FIFO SHALL be a sub-module fifo_2x32 (push, pop, din, dout, count, full, empty). The serializer FSM SHALL live in m32_8.
REQ-029 Target size: 120-400 lines RTL in total.

Verification
REQ-030 Reset: hold reset=1 for 3 cycles with valid_input=1 -> data_32_8=8'hBC, valid_32_8=0, ready_32_8=0, nothing accepted.
REQ-031 Single word: push 32'hDEADBEEF at edge N -> bytes DE, AD, BE, EF at N+2..N+5 with valid_32_8=1, sincout=1 only with DE; then BC with valid_32_8=0.
REQ-032 Back-to-back: valid_input held high with 32'h01020304, 32'h05060708, 32'h090A0B0C -> bytes 01..0C contiguous with no BC gap; ready_32_8 low while 2 words are queued.
REQ-033 Backpressure: present a word while ready_32_8=0 -> word not accepted. It SHALL be accepted the cycle ready_32_8 rises, with the sequence intact.
REQ-034 Mid-word reset: assert reset after byte 1 of 32'hCAFEF00D with one word queued -> next output BC/valid 0; after release, no remnant bytes appear.
REQ-035 Loopback: m32_8 -> m8_32 with 1000 random words and random valid_input gaps -> received words equal sent words, in order.

Source files
------------

// File: rtl/m32_8_pkg.sv
// Shared PHY constants and types for the 32-to-8 serializer and its 8-to-32 counterpart.
// The idle byte is the K28.5 comma character.
package m32_8_pkg;

    localparam logic [7:0] PHY_IDLE_BYTE = 8'hBC;
    localparam int         IDX_W         = 2;
    localparam int         FIFO_DEPTH    = 2;
    localparam int         CNT_W         = 2;
    localparam int         PTR_W         = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    // Byte 0 is the most significant byte, which is the order the 8-to-32 packer rebuilds.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/m32_8_fifo_2x32.sv
// Two-entry word FIFO in front of the serializer.
// Only the control state is reset. The storage is left unreset because it is never read while empty.
module fifo_2x32
    import m32_8_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/m32_8.sv
// 32-to-8 serializer: a two-word FIFO feeds a byte serializer that sends the MSB first.
// When no word is loaded, the output carries the idle comma.
module m32_8
    import m32_8_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = PHY_IDLE_BYTE
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_input,
    input  logic        valid_input,
    output logic        ready_32_8,
    output logic [7:0]  data_32_8,
    output logic        valid_32_8,
    output logic        sincout
);

    ser_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sinc_q, sinc_d;

    logic             fifo_pop;
    logic [31:0]      fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full_unused;

    // ready depends only on the occupancy, so a pop in the same cycle never opens a slot early.
    assign ready_32_8 = !reset && (fifo_count < CNT_W'(FIFO_DEPTH));

    fifo_2x32 u_fifo (
        .clk   (clk_4f),
        .srst  (reset),
        .push  (valid_input && ready_32_8),
        .pop   (fifo_pop),
        .din   (data_input),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full_unused),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_dout;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            default: begin
                if (idx_q == IDX_W'(3)) begin
                    idx_d = '0;
                    // Reload on the last byte so the next word follows without an idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        word_d   = fifo_dout;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        data_d  = IDLE_BYTE;
        valid_d = 1'b0;
        sinc_d  = 1'b0;
        if (state_q == ST_SEND) begin
            data_d  = word_byte(word_q, idx_q);
            valid_d = 1'b1;
            sinc_d  = (idx_q == '0);
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= IDLE_BYTE;
            valid_q <= 1'b0;
            sinc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sinc_q  <= sinc_d;
        end
    end

    always_ff @(posedge clk_4f) begin
        word_q <= word_d;
    end

    assign data_32_8  = data_q;
    assign valid_32_8 = valid_q;
    assign sincout    = sinc_q;

endmodule

// File: tb/tb_m32_8.sv
// Self-checking bench for m32_8. The model is a schedule: each accepted word starts at
// max(accept_edge + 2, previous_start + 4) and is popped from the queue one edge before it starts.
module tb_m32_8;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [31:0] data_input;
    logic        valid_input;
    logic        ready_32_8;
    logic [7:0]  data_32_8;
    logic        valid_32_8;
    logic        sincout;

    m32_8 dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_input  (data_input),
        .valid_input (valid_input),
        .ready_32_8  (ready_32_8),
        .data_32_8   (data_32_8),
        .valid_32_8  (valid_32_8),
        .sincout     (sincout)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic [31:0] w;
        int          s;
    } ent_t;

    ent_t        q[$];
    logic [31:0] sent_q[$];
    int          t;
    int          last_s;
    int          n_checks;
    int          n_fail;

    logic        exp_ready, obs_ready, acc;
    logic [7:0]  exp_data;
    logic        exp_valid, exp_sinc;

    // Drives one cycle from a negedge up to the following negedge, then updates the expected outputs.
    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        int cnt;
        int s;
        valid_input = v;
        data_input  = d;
        reset       = r;
        #1;
        cnt = 0;
        foreach (q[i]) if (q[i].s - 1 > t) cnt++;
        exp_ready = !r && (cnt < 2);
        obs_ready = ready_32_8;
        acc       = v && exp_ready;
        @(posedge clk_4f);
        t++;
        if (r) begin
            q.delete();
            last_s = -1000;
        end else if (acc) begin
            s = (t + 2 > last_s + 4) ? t + 2 : last_s + 4;
            q.push_back('{w: d, s: s});
            sent_q.push_back(d);
            last_s = s;
        end
        @(negedge clk_4f);
        while (q.size() > 0 && q[0].s + 4 <= t) void'(q.pop_front());
        exp_data  = 8'hBC;
        exp_valid = 1'b0;
        exp_sinc  = 1'b0;
        if (q.size() > 0 && q[0].s <= t) begin
            exp_data  = 8'(q[0].w >> (8 * (3 - (t - q[0].s))));
            exp_valid = 1'b1;
            exp_sinc  = (t == q[0].s);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b1);
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {1'b0, 8'hBC, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=0 d=bc v=0 s=0",
                         i, obs_ready, data_32_8, valid_32_8, sincout);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {exp_ready, exp_data, exp_valid, exp_sinc}) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=%b d=%h v=%b s=%b",
                         i, obs_ready, data_32_8, valid_32_8, sincout, exp_ready, exp_data, exp_valid, exp_sinc);
            end
        end
        $display("test_reset done checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_single();
        logic [7:0] bytes_seen[$];
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 32'hDEADBEEF, 1'b0);
            if (valid_32_8) bytes_seen.push_back(data_32_8);
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {exp_ready, exp_data, exp_valid, exp_sinc}) begin
                n_fail++;
                $display("FAIL single cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=%b d=%h v=%b s=%b",
                         i, obs_ready, data_32_8, valid_32_8, sincout, exp_ready, exp_data, exp_valid, exp_sinc);
            end
        end
        n_checks++;
        if (bytes_seen.size() != 4 || {bytes_seen[0], bytes_seen[1], bytes_seen[2], bytes_seen[3]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_bytes got %0d bytes, want DE AD BE EF", bytes_seen.size());
        end
        $display("test_single done checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[3];
        int k;
        bit saw_not_ready;
        words[0] = 32'h01020304;
        words[1] = 32'h05060708;
        words[2] = 32'h090A0B0C;
        k = 0;
        saw_not_ready = 0;
        for (int i = 0; i < 24; i++) begin
            drive(k < 3, (k < 3) ? words[k] : 32'h0, 1'b0);
            if (acc) k++;
            if (!obs_ready) saw_not_ready = 1;
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {exp_ready, exp_data, exp_valid, exp_sinc}) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=%b d=%h v=%b s=%b",
                         i, obs_ready, data_32_8, valid_32_8, sincout, exp_ready, exp_data, exp_valid, exp_sinc);
            end
        end
        n_checks++;
        if (k != 3 || !saw_not_ready) begin
            n_fail++;
            $display("FAIL b2b_accept got accepted=%0d backpressure=%0d want accepted=3 backpressure=1", k, saw_not_ready);
        end
        $display("test_back_to_back done checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 30; i++) begin
            drive(i < 16, $urandom, 1'b0);
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {exp_ready, exp_data, exp_valid, exp_sinc}) begin
                n_fail++;
                $display("FAIL backpressure cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=%b d=%h v=%b s=%b",
                         i, obs_ready, data_32_8, valid_32_8, sincout, exp_ready, exp_data, exp_valid, exp_sinc);
            end
        end
        $display("test_backpressure done checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_midword_reset();
        int guard;
        drive(1'b1, 32'hCAFEF00D, 1'b0);
        drive(1'b1, 32'h12345678, 1'b0);
        guard = 0;
        while (!(exp_valid && exp_data == 8'hFE) && guard < 10) begin
            drive(1'b0, 32'h0, 1'b0);
            guard++;
        end
        n_checks++;
        if ({data_32_8, valid_32_8} !== {8'hFE, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_byte1 got d=%h v=%b want d=fe v=1 (guard=%0d)", data_32_8, valid_32_8, guard);
        end
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if ({obs_ready, data_32_8, valid_32_8, sincout} !== {1'b0, 8'hBC, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_out got rdy=%b d=%h v=%b s=%b want rdy=0 d=bc v=0 s=0",
                     obs_ready, data_32_8, valid_32_8, sincout);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {1'b1, 8'hBC, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL midreset_remnant cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=1 d=bc v=0 s=0",
                         i, obs_ready, data_32_8, valid_32_8, sincout);
            end
        end
        $display("test_midword_reset done checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_loopback();
        logic [31:0] rx_q[$];
        logic [31:0] rx_word;
        int          nb;
        int          cyc;
        sent_q.delete();
        nb  = 0;
        cyc = 0;
        rx_word = '0;
        while ((sent_q.size() < 1000 || cyc < 0) && cyc < 20000) begin
            drive(sent_q.size() < 1000 && ($urandom_range(0, 9) < 7), $urandom, 1'b0);
            cyc++;
            if (valid_32_8) begin
                nb      = sincout ? 1 : nb + 1;
                rx_word = {rx_word[23:0], data_32_8};
                if (nb == 4) rx_q.push_back(rx_word);
            end
            n_checks++;
            if ({obs_ready, data_32_8, valid_32_8, sincout} !== {exp_ready, exp_data, exp_valid, exp_sinc}) begin
                n_fail++;
                $display("FAIL loopback cyc=%0d got rdy=%b d=%h v=%b s=%b want rdy=%b d=%h v=%b s=%b",
                         cyc, obs_ready, data_32_8, valid_32_8, sincout, exp_ready, exp_data, exp_valid, exp_sinc);
            end
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            if (valid_32_8) begin
                nb      = sincout ? 1 : nb + 1;
                rx_word = {rx_word[23:0], data_32_8};
                if (nb == 4) rx_q.push_back(rx_word);
            end
        end
        n_checks++;
        if (rx_q.size() != sent_q.size() || sent_q.size() != 1000) begin
            n_fail++;
            $display("FAIL loopback_count got rx=%0d sent=%0d want both 1000", rx_q.size(), sent_q.size());
        end else begin
            for (int i = 0; i < 1000; i++) begin
                n_checks++;
                if (rx_q[i] !== sent_q[i]) begin
                    n_fail++;
                    $display("FAIL loopback_word idx=%0d got %h want %h", i, rx_q[i], sent_q[i]);
                end
            end
        end
        $display("test_loopback done checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        t           = 0;
        last_s      = -1000;
        reset       = 1'b1;
        valid_input = 1'b0;
        data_input  = '0;
        @(negedge clk_4f);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_midword_reset();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
